// File: rtl/i2s_master_tx_pkg.sv
// Shared audio definitions for the I2S transmit path: sample width,
// default timing parameters, FSM state encoding and the stereo sample type.
package i2s_master_tx_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int CLK_DIV_DEF   = 2;
  localparam int SLOT_BITS_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT
  } i2s_state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

endpackage

// File: rtl/i2s_master_tx_clk_div.sv
// BCLK divider: toggles o_bclk every CLK_DIV i_clk cycles while enabled.
// o_fall / o_rise flag the i_clk edge on which o_bclk will go 1->0 / 0->1,
// so the consumer can update its registers on that same edge.
module i2s_clk_div
  import i2s_master_tx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_bclk,
  output logic o_fall,
  output logic o_rise
);

  localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic       bclk_q;
  logic       tick;

  assign tick   = i_en && (cnt_q == TERM);
  assign o_bclk = bclk_q;
  assign o_fall = tick && bclk_q;
  assign o_rise = tick && !bclk_q;

  // Half-period counter and BCLK toggle; disabled means parked at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else if (!i_en) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else if (tick) begin
      cnt_q  <= '0;
      bclk_q <= !bclk_q;
    end else begin
      cnt_q  <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: generates BCLK/LRCK and shifts out 16-bit stereo
// samples MSB first with the standard one-BCLK delay after each LRCK edge.
// One sample pair is buffered in a holding register ahead of the shifter.
module i2s_master_tx
  import i2s_master_tx_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic [SAMPLE_W-1:0] i_left,
  input  logic [SAMPLE_W-1:0] i_right,
  output logic                o_ready,
  output logic                o_bclk,
  output logic                o_lrck,
  output logic                o_sdat,
  output logic                o_frame_done,
  output logic                o_underrun
);

  localparam logic [6:0] LAST_POS = 7'(SLOT_BITS - 1);
  localparam logic [6:0] DATA_END = 7'(SAMPLE_W);

  i2s_state_e              state_q, state_d;
  logic [6:0]              bit_cnt_q, bit_cnt_d;
  logic [2*SAMPLE_W-1:0]   shreg_q, shreg_d;
  stereo_t                 hold_q, hold_d;
  logic                    full_q, full_d;
  logic                    lrck_q, lrck_d;
  logic                    sdat_q, sdat_d;
  logic                    fdone_q, fdone_d;
  logic                    under_q, under_d;
  logic                    fall, bclk_rise_unused;
  logic                    xfer, load, last;

  i2s_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .o_bclk  (o_bclk),
    .o_fall  (fall),
    .o_rise  (bclk_rise_unused)
  );

  assign xfer         = i_valid && !full_q;
  assign last         = (bit_cnt_q == LAST_POS);
  assign o_ready      = !full_q;
  assign o_lrck       = lrck_q;
  assign o_sdat       = sdat_q;
  assign o_frame_done = fdone_q;
  assign o_underrun   = under_q;

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      hold_q    <= '0;
      full_q    <= 1'b0;
      lrck_q    <= 1'b1;
      sdat_q    <= 1'b0;
      fdone_q   <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
      full_q    <= full_d;
      lrck_q    <= lrck_d;
      sdat_q    <= sdat_d;
      fdone_q   <= fdone_d;
      under_q   <= under_d;
    end
  end

  // Slot sequencing on BCLK fall events, frame loads and holding-register handshake.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    full_d    = full_q;
    lrck_d    = lrck_q;
    sdat_d    = sdat_q;
    fdone_d   = 1'b0;
    under_d   = 1'b0;
    load      = 1'b0;

    if (!i_en) begin
      // Abort: park outputs at idle values, keep whatever is held.
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      lrck_d    = 1'b1;
      sdat_d    = 1'b0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_LEFT;
          lrck_d    = 1'b0;
          bit_cnt_d = '0;
          sdat_d    = 1'b0;
          load      = 1'b1;
        end
        default: begin
          if (last) begin
            bit_cnt_d = '0;
            sdat_d    = 1'b0;
            if (state_q == S_LEFT) begin
              state_d = S_RIGHT;
              lrck_d  = 1'b1;
            end else begin
              state_d = S_LEFT;
              lrck_d  = 1'b0;
              fdone_d = 1'b1;
              load    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
            // Positions 1..16 carry data; everything after is padding.
            if (bit_cnt_q < DATA_END) begin
              sdat_d  = shreg_q[2*SAMPLE_W-1];
              shreg_d = {shreg_q[2*SAMPLE_W-2:0], 1'b0};
            end else begin
              sdat_d  = 1'b0;
            end
          end
        end
      endcase
    end

    if (load) begin
      if (full_q) begin
        shreg_d = hold_q;
        hold_d  = '0;
        full_d  = 1'b0;
      end else begin
        shreg_d = '0;
        under_d = 1'b1;
      end
    end

    // A transfer only happens when empty, so it never collides with a
    // load that consumes the holding register; it refills it for next frame.
    if (xfer) begin
      hold_d = '{left: i_left, right: i_right};
      full_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_master_tx.sv
// Self-checking bench for i2s_master_tx: a time-based reference model
// compared every cycle, a BCLK-rise receiver, and directed literal checks.
module tb_i2s_master_tx;

  localparam int CD = 2;
  localparam int SB = 32;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_left = '0;
  logic [15:0] i_right = '0;
  logic        o_ready, o_bclk, o_lrck, o_sdat, o_frame_done, o_underrun;

  int total = 0;
  int bad   = 0;
  int rnd_mode = 0;

  always #5 i_clk = ~i_clk;

  i2s_master_tx #(.CLK_DIV(CD), .SLOT_BITS(SB)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_valid      (i_valid),
    .i_left       (i_left),
    .i_right      (i_right),
    .o_ready      (o_ready),
    .o_bclk       (o_bclk),
    .o_lrck       (o_lrck),
    .o_sdat       (o_sdat),
    .o_frame_done (o_frame_done),
    .o_underrun   (o_underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs derived from elapsed enabled cycles.
  int          m_k = 0;
  logic        m_full = 1'b0;
  logic [31:0] m_hold = '0, m_frame = '0;
  logic        e_bclk = 1'b0, e_lrck = 1'b1, e_sdat = 1'b0, e_fd = 1'b0, e_ur = 1'b0;

  always @(posedge i_clk or negedge i_rst_n) begin : model
    int kn, q, p;
    bit ld, xf;
    if (!i_rst_n) begin
      m_k <= 0; m_full <= 1'b0; m_hold <= '0; m_frame <= '0;
      e_bclk <= 1'b0; e_lrck <= 1'b1; e_sdat <= 1'b0; e_fd <= 1'b0; e_ur <= 1'b0;
    end else begin
      xf = i_valid && !m_full;
      ld = 1'b0;
      kn = i_en ? m_k + 1 : 0;
      m_k    <= kn;
      e_bclk <= ((kn / CD) % 2) == 1;
      e_fd   <= 1'b0;
      e_ur   <= 1'b0;
      if (!i_en) begin
        e_lrck <= 1'b1;
        e_sdat <= 1'b0;
      end else if (kn % (2*CD) == 0) begin
        q = (kn / (2*CD) - 1) % (2*SB);
        p = q % SB;
        ld = (q == 0);
        e_lrck <= (q >= SB);
        e_fd   <= ld && (kn > 2*CD);
        e_sdat <= (p >= 1 && p <= 16) ? ((q >= SB) ? m_frame[16-p] : m_frame[32-p]) : 1'b0;
      end
      if (ld) begin
        if (m_full) begin m_frame <= m_hold; m_hold <= '0; end
        else begin m_frame <= '0; e_ur <= 1'b1; end
      end
      m_full <= xf ? 1'b1 : (ld ? 1'b0 : m_full);
      if (xf) m_hold <= {i_left, i_right};
    end
  end

  // Compare process, event counters and a receiver sampling on BCLK rise.
  int          ur_cnt = 0, fd_cnt = 0, xf_cnt = 0, rx_pos = 0;
  logic        prev_bclk = 1'b0, prev_lrck = 1'b1;
  logic [15:0] rx_word = '0, rx_left = '0, rx_right = '0;

  always @(negedge i_clk) begin : compare
    logic [15:0] nw;
    int pos;
    check("bclk",  {31'd0, o_bclk},       {31'd0, e_bclk});
    check("lrck",  {31'd0, o_lrck},       {31'd0, e_lrck});
    check("sdat",  {31'd0, o_sdat},       {31'd0, e_sdat});
    check("ready", {31'd0, o_ready},      {31'd0, !m_full});
    check("fdone", {31'd0, o_frame_done}, {31'd0, e_fd});
    check("under", {31'd0, o_underrun},   {31'd0, e_ur});
    if (o_underrun) ur_cnt <= ur_cnt + 1;
    if (o_frame_done) fd_cnt <= fd_cnt + 1;
    if (i_valid && o_ready && i_rst_n) xf_cnt <= xf_cnt + 1;
    pos = (o_lrck !== prev_lrck) ? 0 : rx_pos;
    if (o_bclk && !prev_bclk) begin
      if (pos >= 1 && pos <= 16) begin
        nw = {rx_word[14:0], o_sdat};
        rx_word <= nw;
        if (pos == 16) begin
          if (o_lrck) rx_right <= nw;
          else        rx_left  <= nw;
        end
      end
      pos = pos + 1;
    end
    rx_pos    <= pos;
    prev_bclk <= o_bclk;
    prev_lrck <= o_lrck;
  end

  // Background input driver for back-to-back and random phases.
  initial forever begin
    @(posedge i_clk);
    #2;
    if (rnd_mode == 1) begin
      i_valid = 1'b1; i_left = 16'($urandom); i_right = 16'($urandom);
    end else if (rnd_mode == 2) begin
      i_valid = ($urandom_range(0, 2) == 0); i_left = 16'($urandom); i_right = 16'($urandom);
    end
  end

  // Wait (bounded) until o_lrck reads v, sampling 1 time unit after each edge.
  task automatic wait_lrck(input logic v, output int n);
    n = 0;
    do begin
      @(posedge i_clk); #1; n++;
    end while (o_lrck !== v && n < 2000);
    if (o_lrck !== v) begin
      total++; bad++;
      $display("FAIL wait_lrck: got lrck=%0b want %0b after %0d cycles", o_lrck, v, n);
    end
  endtask

  initial begin : main
    int n1, n2, ur0, fd0, xf0;
    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_bclk",  {31'd0, o_bclk}, 32'd0);
    check("rst_lrck",  {31'd0, o_lrck}, 32'd1);
    check("rst_sdat",  {31'd0, o_sdat}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_fdone", {31'd0, o_frame_done}, 32'd0);
    check("rst_under", {31'd0, o_underrun}, 32'd0);
    #1 i_rst_n = 1'b1;

    // Preload one stereo pair, then enable
    @(posedge i_clk); #2 i_valid = 1'b1; i_left = 16'hA5C3; i_right = 16'h8001;
    @(posedge i_clk); #2 i_valid = 1'b0; i_en = 1'b1;
    wait_lrck(1'b0, n1);
    check("first_lrck_fall", n1, 32'd4);
    wait_lrck(1'b1, n1);
    check("rx_left_a5c3", {16'd0, rx_left}, 32'h0000A5C3);
    check("no_underrun_f1", ur_cnt, 32'd0);
    ur0 = ur_cnt; fd0 = fd_cnt;
    wait_lrck(1'b0, n2);
    check("lrck_period", n1 + n2, 32'd256);
    check("rx_right_8001", {16'd0, rx_right}, 32'h00008001);

    // Empty holding register at the next load
    wait_lrck(1'b1, n1);
    check("underrun_once", ur_cnt - ur0, 32'd1);
    check("fdone_once", fd_cnt - fd0, 32'd1);
    check("rx_left_zero", {16'd0, rx_left}, 32'd0);
    wait_lrck(1'b0, n2);
    check("rx_right_zero", {16'd0, rx_right}, 32'd0);

    // Back-to-back offers with i_valid held high
    wait_lrck(1'b1, n1);
    rnd_mode = 1;
    wait_lrck(1'b0, n1);
    xf0 = xf_cnt; ur0 = ur_cnt; fd0 = fd_cnt;
    repeat (3) begin
      wait_lrck(1'b1, n1);
      wait_lrck(1'b0, n2);
    end
    check("b2b_transfers", xf_cnt - xf0, 32'd3);
    check("b2b_underruns", ur_cnt - ur0, 32'd0);
    check("b2b_fdone", fd_cnt - fd0, 32'd3);

    // Hold a known pair, drop i_en at left slot position 8, re-enable
    rnd_mode = 0;
    #1 i_valid = 1'b1; i_left = 16'h1234; i_right = 16'h5678;
    @(posedge i_clk); #2 i_valid = 1'b0;
    repeat (32) @(posedge i_clk);
    #2 i_en = 1'b0;
    @(posedge i_clk); #1;
    check("abort_bclk", {31'd0, o_bclk}, 32'd0);
    check("abort_lrck", {31'd0, o_lrck}, 32'd1);
    check("abort_sdat", {31'd0, o_sdat}, 32'd0);
    check("abort_ready", {31'd0, o_ready}, 32'd0);
    repeat (5) @(posedge i_clk);
    #2 i_en = 1'b1;
    wait_lrck(1'b0, n1);
    check("reen_lrck_fall", n1, 32'd4);
    ur0 = ur_cnt;
    wait_lrck(1'b1, n1);
    check("held_left", {16'd0, rx_left}, 32'h00001234);
    check("reen_no_underrun", ur_cnt - ur0, 32'd0);
    wait_lrck(1'b0, n2);
    check("held_right", {16'd0, rx_right}, 32'h00005678);

    // Random offers checked by the model
    rnd_mode = 2;
    repeat (6) begin
      wait_lrck(1'b1, n1);
      wait_lrck(1'b0, n2);
    end

    // Asynchronous reset in the middle of a right slot
    wait_lrck(1'b1, n1);
    rnd_mode = 0;
    #1 i_valid = 1'b0;
    repeat (20) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("arst_bclk",  {31'd0, o_bclk}, 32'd0);
    check("arst_lrck",  {31'd0, o_lrck}, 32'd1);
    check("arst_sdat",  {31'd0, o_sdat}, 32'd0);
    check("arst_ready", {31'd0, o_ready}, 32'd1);
    check("arst_fdone", {31'd0, o_frame_done}, 32'd0);
    check("arst_under", {31'd0, o_underrun}, 32'd0);
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    wait_lrck(1'b0, n1);
    check("post_rst_lrck_fall", n1, 32'd4);
    wait_lrck(1'b1, n1);
    wait_lrck(1'b0, n2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_master_tx.md
I2S_MASTER_TX -- requirements
Module: i2s_master_tx

Interface
REQ-001 The block SHALL take parameter CLK_DIV, default 2: i_clk cycles per BCLK half-period, legal range 1..255.
REQ-002 The block SHALL take parameter SLOT_BITS, default 32: BCLK cycles per channel slot, legal range 17..64.
REQ-003 The reset SHALL be i_rst_n, asynchronous, active-low, and the clock SHALL be i_clk.
REQ-004 The block SHALL have these ports, one per line (name, direction, width, meaning):
- i_clk  in  1  system clock
- i_rst_n  in  1  async active-low reset
- i_en  in  1  enables BCLK/LRCK generation and transmission
- i_valid  in  1  stereo sample offered
- i_left  in  16  left sample, two's complement
- i_right  in  16  right sample, two's complement
- o_ready  out  1  holding register empty; transfer on i_valid && o_ready
- o_bclk  out  1  I2S bit clock
- o_lrck  out  1  I2S word select; 0 = left, 1 = right
- o_sdat  out  1  I2S serial data, MSB first
- o_frame_done  out  1  1-cycle pulse at end of each right slot
- o_underrun  out  1  1-cycle pulse when a frame starts with the holding register empty

Function
REQ-005 The divider SHALL toggle o_bclk every CLK_DIV i_clk cycles while i_en=1, giving a BCLK period of 2*CLK_DIV cycles.
REQ-006 A "fall event" SHALL be the i_clk edge on which o_bclk goes 1->0; o_lrck and o_sdat SHALL change only on fall events, so a receiver can sample on BCLK rising.
REQ-007 The FSM SHALL have three states: S_IDLE, S_LEFT and S_RIGHT.
REQ-008 In S_IDLE, the block SHALL hold o_bclk=0, o_lrck=1, o_sdat=0 and the divider at 0.
REQ-009 When i_en rises in S_IDLE, the first fall event SHALL occur 2*CLK_DIV cycles later; at that event o_lrck SHALL go 0, the state SHALL become S_LEFT, bit_cnt SHALL be 0, and a frame load SHALL occur.
REQ-010 A frame load SHALL copy the holding register into a 32-bit shift register {L,R} and clear the holding register; if the holding register is empty, the block SHALL load zeros and pulse o_underrun.
REQ-011 bit_cnt SHALL count from 0 to SLOT_BITS-1 on fall events within each slot.
REQ-012 At slot positions 1..16, o_sdat SHALL carry sample bits 15..0; at position 0 and positions 17..SLOT_BITS-1, o_sdat SHALL be 0 (one-BCLK I2S delay).
REQ-013 At the fall event ending position SLOT_BITS-1: in S_LEFT, the block SHALL enter S_RIGHT with o_lrck=1; in S_RIGHT, it SHALL pulse o_frame_done, enter S_LEFT with o_lrck=0, and perform a frame load.
REQ-014 o_ready SHALL equal NOT(holding full); a transfer SHALL set holding full on the next edge.
REQ-015 If a frame load and a transfer coincide while the holding register is empty, the block SHALL declare underrun for the current frame and keep the transferred sample for the next frame.
REQ-016 When i_en falls in any state, the block SHALL return to S_IDLE on the next edge and abort the current frame; the holding register SHALL keep its contents and no pulse SHALL be generated.
REQ-017 The block SHALL operate continuously, with no gap between frames; a frame SHALL be 2*SLOT_BITS BCLK long.

Reset
REQ-018 Reset SHALL force S_IDLE, o_bclk=0, o_lrck=1, o_sdat=0, o_frame_done=0, o_underrun=0 and o_ready=1, and SHALL clear the divider, bit_cnt, shift register and holding register.
REQ-019 Reset asserted mid-frame SHALL take effect immediately; after release, the block SHALL restart per REQ-009.

Structure
REQ-020 The state enum, the 16-bit sample width, and the default CLK_DIV and SLOT_BITS values SHALL live in the shared audio package.
REQ-021 The BCLK divider SHALL be one sub-module, i2s_clk_div, with outputs o_bclk, o_fall and o_rise; the FSM and shifter SHALL live in the top module.

Verification
REQ-022 The bench SHALL cover: reset, i_en=1 with CLK_DIV=2 and SLOT_BITS=32 -> first o_lrck fall at cycle 4; o_lrck period 256 cycles.
REQ-023 The bench SHALL cover: preload L=16'hA5C3, R=16'h8001 -> receiver samples on BCLK rise give A5C3 on slot bits 1..16 with o_lrck=0, and 8001 with o_lrck=1.
REQ-024 The bench SHALL cover: no sample offered before a frame load -> o_underrun pulses once, o_sdat=0 for the whole frame, o_frame_done still pulses.
REQ-025 The bench SHALL cover: back-to-back samples driven with i_valid held high -> exactly one transfer per frame, o_ready low from transfer until the next load, no underrun.
REQ-026 The bench SHALL cover: i_en dropped at left slot position 8, then re-raised -> idle values the next cycle, held sample transmitted intact in the next frame.
REQ-027 The bench SHALL cover: i_rst_n asserted mid-right-slot -> all outputs at reset values asynchronously and o_ready=1.
